// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and the
// alignment rule used when a request is accepted.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'd0,
    HALF    = 2'd1,
    WORD    = 2'd2,
    ILLEGAL = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // Size 3 is never legal, so it reports as misaligned at every offset.
  function automatic logic is_aligned(size_e size, logic [1:0] off);
    case (size)
      BYTE:    return 1'b1;
      HALF:    return ~off[0];
      WORD:    return (off == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane extraction: shifts the addressed byte/half down to
// bit 0 and sign- or zero-extends it; word reads pass through untouched.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [15:0] lane;

  function automatic logic [31:0] ext8(logic [7:0] v, logic zext);
    logic signed [7:0] s;
    s = v;
    return zext ? {24'b0, v} : 32'(s);
  endfunction

  function automatic logic [31:0] ext16(logic [15:0] v, logic zext);
    logic signed [15:0] s;
    s = v;
    return zext ? {16'b0, v} : 32'(s);
  endfunction

  always_comb begin
    lane = 16'(rdata_i >> {off_i, 3'b000});
    case (size_e'(size_i))
      BYTE:    data_o = ext8(lane[7:0], unsigned_i);
      HALF:    data_o = ext16(lane, unsigned_i);
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// LSU front end: one outstanding load/store, word-aligned memory request with
// byte-lane strobes, extended load response, misaligned accesses rejected.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int MEM_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wen_q, wen_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  size_e            size_q, size_d;
  logic             uns_q, uns_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             accept;
  logic             req_ok;
  logic             last_beat;
  logic [31:0]      load_data;
  logic [3:0]       st_mask;
  logic [31:0]      st_data;

  assign accept    = (state_q == IDLE) && req_valid;
  assign req_ok    = is_aligned(size_e'(req_size), req_addr[1:0]);
  assign last_beat = (state_q == ACCESS) && (cnt_q == '0);

  lsu_load_align u_load_align (
    .rdata_i    (mem_rdata),
    .off_i      (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= BYTE;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = req_ok ? ACCESS : RESP;
      ACCESS:  if (cnt_q == '0) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured once at accept; the response register is
  // loaded either at accept (error) or on the final ACCESS beat.
  always_comb begin
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      wen_d   = req_wen;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      size_d  = size_e'(req_size);
      uns_d   = req_unsigned;
      rdata_d = '0;
      err_d   = ~req_ok;
      cnt_d   = req_ok ? CNT_W'(MEM_LAT) : '0;
    end else if (last_beat) begin
      rdata_d = wen_q ? '0 : load_data;
    end else if (state_q == ACCESS) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    st_mask = 4'b0000;
    st_data = '0;
    case (size_q)
      BYTE: begin
        st_mask = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      HALF: begin
        st_mask = 4'b0011 << addr_q[1:0];
        st_data = {2{wdata_q[15:0]}};
      end
      WORD: begin
        st_mask = 4'b1111;
        st_data = wdata_q;
      end
      default: begin
        st_mask = 4'b0000;
        st_data = '0;
      end
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_rdata = resp_valid ? rdata_q : '0;
    resp_err   = resp_valid & err_q;
    mem_valid  = (state_q == ACCESS);
    mem_wen    = mem_valid & wen_q;
    mem_raddr  = {addr_q[31:2], 2'b00};
    mem_waddr  = {addr_q[31:2], 2'b00};
    mem_wdata  = mem_wen ? st_data : '0;
    mem_wmask  = mem_wen ? {4'b0000, st_mask} : 8'h00;
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: one zero-latency instance for the data
// paths and error/reset cases, one MEM_LAT=2 instance for latency and backpressure.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          failures = 0;
  int          n_mv;

  logic        req_valid0, req_ready0, req_wen0, req_unsigned0;
  logic [31:0] req_addr0, req_wdata0;
  logic [1:0]  req_size0;
  logic        resp_valid0, resp_ready0, resp_err0;
  logic [31:0] resp_rdata0;
  logic        mem_valid0, mem_wen0;
  logic [31:0] mem_raddr0, mem_waddr0, mem_wdata0, mem_rdata0;
  logic [7:0]  mem_wmask0;

  logic        req_valid2, req_ready2, req_wen2, req_unsigned2;
  logic [31:0] req_addr2, req_wdata2;
  logic [1:0]  req_size2;
  logic        resp_valid2, resp_ready2, resp_err2;
  logic [31:0] resp_rdata2;
  logic        mem_valid2, mem_wen2;
  logic [31:0] mem_raddr2, mem_waddr2, mem_wdata2, mem_rdata2;
  logic [7:0]  mem_wmask2;

  always #5 clk = ~clk;

  lsu_mem_port #(.MEM_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_wen(req_wen0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_size(req_size0),
    .req_unsigned(req_unsigned0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0),
    .mem_valid(mem_valid0), .mem_wen(mem_wen0),
    .mem_raddr(mem_raddr0), .mem_waddr(mem_waddr0),
    .mem_wdata(mem_wdata0), .mem_wmask(mem_wmask0), .mem_rdata(mem_rdata0)
  );

  lsu_mem_port #(.MEM_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_wen(req_wen2),
    .req_addr(req_addr2), .req_wdata(req_wdata2), .req_size(req_size2),
    .req_unsigned(req_unsigned2),
    .resp_valid(resp_valid2), .resp_ready(resp_ready2),
    .resp_rdata(resp_rdata2), .resp_err(resp_err2),
    .mem_valid(mem_valid2), .mem_wen(mem_wen2),
    .mem_raddr(mem_raddr2), .mem_waddr(mem_waddr2),
    .mem_wdata(mem_wdata2), .mem_wmask(mem_wmask2), .mem_rdata(mem_rdata2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full zero-latency transaction on dut0 with expected memory-side and response values.
  task automatic do_acc(input string tag, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                        input logic [31:0] rdata, input logic [3:0] exp_mask,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_resp);
    chk({tag, ".req_ready"}, req_ready0, 1);
    req_valid0 = 1'b1; req_wen0 = wen; req_addr0 = addr; req_wdata0 = wdata;
    req_size0 = size; req_unsigned0 = uns; mem_rdata0 = rdata; resp_ready0 = 1'b0;
    step();
    req_valid0 = 1'b0;
    chk({tag, ".mem_valid"}, mem_valid0, 1);
    chk({tag, ".mem_wen"}, mem_wen0, {31'b0, wen});
    chk({tag, ".mem_raddr"}, mem_raddr0, {addr[31:2], 2'b00});
    chk({tag, ".mem_waddr"}, mem_waddr0, {addr[31:2], 2'b00});
    chk({tag, ".mem_wmask"}, mem_wmask0, {28'b0, exp_mask});
    chk({tag, ".mem_wdata"}, mem_wdata0, exp_wdata);
    chk({tag, ".acc_resp_valid"}, resp_valid0, 0);
    step();
    mem_rdata0 = 32'h5A5A_5A5A;
    chk({tag, ".resp_valid"}, resp_valid0, 1);
    chk({tag, ".resp_err"}, resp_err0, 0);
    chk({tag, ".resp_rdata"}, resp_rdata0, exp_resp);
    chk({tag, ".resp_mem_valid"}, mem_valid0, 0);
    resp_ready0 = 1'b1;
    step();
    resp_ready0 = 1'b0;
    chk({tag, ".idle_req_ready"}, req_ready0, 1);
    chk({tag, ".idle_resp_valid"}, resp_valid0, 0);
  endtask

  task automatic do_err(input string tag, input logic wen, input logic [31:0] addr,
                        input logic [1:0] size);
    req_valid0 = 1'b1; req_wen0 = wen; req_addr0 = addr; req_wdata0 = 32'hFFFF_FFFF;
    req_size0 = size; req_unsigned0 = 1'b0; resp_ready0 = 1'b0;
    step();
    req_valid0 = 1'b0;
    chk({tag, ".resp_valid"}, resp_valid0, 1);
    chk({tag, ".resp_err"}, resp_err0, 1);
    chk({tag, ".resp_rdata"}, resp_rdata0, 0);
    chk({tag, ".mem_valid"}, mem_valid0, 0);
    chk({tag, ".mem_wmask"}, mem_wmask0, 0);
    resp_ready0 = 1'b1;
    step();
    resp_ready0 = 1'b0;
    chk({tag, ".idle_mem_valid"}, mem_valid0, 0);
    chk({tag, ".idle_req_ready"}, req_ready0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid0 = 0; req_wen0 = 0; req_addr0 = 0; req_wdata0 = 0; req_size0 = 0;
    req_unsigned0 = 0; resp_ready0 = 0; mem_rdata0 = 0;
    req_valid2 = 0; req_wen2 = 0; req_addr2 = 0; req_wdata2 = 0; req_size2 = 0;
    req_unsigned2 = 0; resp_ready2 = 0; mem_rdata2 = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst.req_ready", req_ready0, 1);
    chk("rst.resp_valid", resp_valid0, 0);
    chk("rst.resp_rdata", resp_rdata0, 0);
    chk("rst.mem_valid", mem_valid0, 0);
    chk("rst.mem_raddr", mem_raddr0, 0);
    chk("rst.mem_wmask", mem_wmask0, 0);

    do_acc("lb",  1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0, 32'h80FF_1234, 4'h0, 32'h0, 32'hFFFF_FF80);
    do_acc("lhu", 1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b1, 32'h8001_0000, 4'h0, 32'h0, 32'h0000_8001);
    do_acc("sb",  1'b1, 32'h8000_0001, 32'h0000_00AB, 2'd0, 1'b0, 32'h0, 4'h2, 32'hABAB_ABAB, 32'h0);
    do_acc("sh",  1'b1, 32'h0000_0042, 32'h1234_5678, 2'd1, 1'b0, 32'h0, 4'hC, 32'h5678_5678, 32'h0);
    do_acc("sw",  1'b1, 32'h0000_0100, 32'hCAFE_F00D, 2'd2, 1'b0, 32'h0, 4'hF, 32'hCAFE_F00D, 32'h0);
    do_acc("lh",  1'b0, 32'h0000_0200, 32'h0, 2'd1, 1'b0, 32'h0000_F00F, 4'h0, 32'h0, 32'hFFFF_F00F);
    do_acc("lbu", 1'b0, 32'h0000_0301, 32'h0, 2'd0, 1'b1, 32'h0000_9A00, 4'h0, 32'h0, 32'h0000_009A);
    do_acc("lbp", 1'b0, 32'h0000_0302, 32'h0, 2'd0, 1'b0, 32'h007F_0000, 4'h0, 32'h0, 32'h0000_007F);
    do_acc("lw",  1'b0, 32'h0000_0400, 32'h0, 2'd2, 1'b0, 32'h8765_4321, 4'h0, 32'h0, 32'h8765_4321);

    do_err("lw_mis", 1'b0, 32'h8000_0002, 2'd2);
    do_err("sh_mis", 1'b1, 32'h0000_0007, 2'd1);
    do_err("size3",  1'b0, 32'h0000_0000, 2'd3);

    // MEM_LAT=2: count ACCESS beats, then hold the response under backpressure.
    req_valid2 = 1'b1; req_wen2 = 1'b0; req_addr2 = 32'h0000_0010; req_size2 = 2'd1;
    req_unsigned2 = 1'b0; mem_rdata2 = 32'h1234_8765; resp_ready2 = 1'b0;
    step();
    req_valid2 = 1'b0;
    n_mv = 0;
    for (int i = 0; i < 10 && !resp_valid2; i++) begin
      if (mem_valid2) n_mv++;
      step();
    end
    mem_rdata2 = 32'h0;
    chk("lat2.mem_valid_cycles", 32'(n_mv), 3);
    for (int k = 0; k < 3; k++) begin
      chk("lat2.resp_valid", resp_valid2, 1);
      chk("lat2.resp_rdata", resp_rdata2, 32'hFFFF_8765);
      chk("lat2.resp_err", resp_err2, 0);
      chk("lat2.req_ready", req_ready2, 0);
      step();
    end
    resp_ready2 = 1'b1;
    chk("lat2.resp_valid_last", resp_valid2, 1);
    step();
    resp_ready2 = 1'b0;
    chk("lat2.req_ready_back", req_ready2, 1);
    chk("lat2.resp_valid_drop", resp_valid2, 0);

    // Asynchronous reset in the middle of an ACCESS.
    req_valid0 = 1'b1; req_wen0 = 1'b1; req_addr0 = 32'h0000_0020; req_wdata0 = 32'h11;
    req_size0 = 2'd0; resp_ready0 = 1'b0;
    step();
    req_valid0 = 1'b0;
    chk("arst.pre_mem_valid", mem_valid0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.mem_valid", mem_valid0, 0);
    chk("arst.mem_wmask", mem_wmask0, 0);
    #8 rst_n = 1'b1;
    step();
    chk("arst.req_ready", req_ready0, 1);
    chk("arst.resp_valid", resp_valid0, 0);
    chk("arst.mem_valid_after", mem_valid0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
